cycle_count_display: RTL and testbench

//  Consumes the 32-bit sorting cycle count produced by the clock/counter stage and shows it in

---
 rtl/cycle_disp_pkg.sv | 45 ++++
 rtl/bin2bcd_seq.sv | 79 +++++++
 rtl/cycle_count_display.sv | 114 +++++++++++
 tb/tb_cycle_count_display.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_disp_pkg.sv
// Shared definitions for the cycle-count display: converter state encoding,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-low) and datapath widths.
package cycle_disp_pkg;

    localparam int BIN_WIDTH  = 32;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_WIDTH  = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibble codes above 9 cannot come out of the converter; show them blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock.
//
//  state | meaning
//  IDLE  | waiting for start; latches bin_in on start
//  SHIFT | 32 add-3/shift iterations, one per clock
//  DONE  | bcd_out complete, valid=1 for one cycle
module bin2bcd_seq
    import cycle_disp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 valid,
    output logic [BCD_WIDTH-1:0] bcd_out
);

    localparam int ITER_W = $clog2(BIN_WIDTH);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_WIDTH - 1);

    conv_state_t          state, state_next;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCD_WIDTH-1:0] bcd, bcd_adj;
    logic [ITER_W-1:0]    iter;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; iter is a down-counter whose terminal count ends SHIFT
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (iter == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Shift datapath: load on start, shift the adjusted BCD and binary together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr <= '0;
            bcd    <= '0;
            iter   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    bin_sr <= bin_in;
                    bcd    <= '0;
                    iter   <= ITER_LAST;
                end
                ST_SHIFT: begin
                    bcd    <= {bcd_adj[BCD_WIDTH-2:0], bin_sr[BIN_WIDTH-1]};
                    bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
                    iter   <= iter - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign valid   = (state == ST_DONE);
    assign bcd_out = bcd;

endmodule

// File: rtl/cycle_count_display.sv
// Shows the 32-bit cycle count in decimal on a multiplexed seven-segment display.
// Change detection, overflow dashes, optional leading-zero blanking, digit scan
// and segment decode live here; conversion is done by bin2bcd_seq.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks zeros above the top nonzero digit.
module cycle_count_display
    import cycle_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_BITS = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_WIDTH-1:0]  count_in,
    input  logic                  done_in,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int SEL_W  = $clog2(NUM_DIGITS);
    localparam int DISP_W = 4 * NUM_DIGITS;

    logic [BIN_WIDTH-1:0]    last_val;
    logic                    start, conv_valid;
    logic [BCD_WIDTH-1:0]    conv_bcd;
    logic [DISP_W-1:0]       disp;
    logic                    overflow;
    logic [REFRESH_BITS-1:0] scan;
    logic [SEL_W-1:0]        sel;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    zero_run;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic [6:0]              seg_next;

    // A new conversion starts whenever the input differs from the last value taken;
    // changes while busy are caught by this same compare once the converter is idle.
    assign start = (count_in != last_val) && !busy;
    assign sel   = scan[REFRESH_BITS-1 -: SEL_W];

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (count_in),
        .busy    (busy),
        .valid   (conv_valid),
        .bcd_out (conv_bcd)
    );

    // Track the converted value and update the display digits atomically on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val <= '0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            if (start) last_val <= count_in;
            if (conv_valid) begin
                disp     <= conv_bcd[DISP_W-1:0];
                overflow <= |conv_bcd[BCD_WIDTH-1:DISP_W];
            end
        end
    end

    // Free-running scan counter; its top bits pick the active digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan <= '0;
        else     scan <= scan + 1'b1;
    end

    // Mark digits that are zero with only zeros above them; digit 0 always shows
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (disp[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
        lead_zero[0] = 1'b0;
`endif
    end

    // Select the active digit and decode its segments
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel == SEL_W'(k)) begin
                cur_digit = disp[4*k +: 4];
                cur_blank = lead_zero[k];
            end
        end
        if (overflow)       seg_next = SEG_DASH;
        else if (cur_blank) seg_next = SEG_BLANK;
        else                seg_next = seg_decode(cur_digit);
    end

    // Registered pin drivers so reset forces the display dark without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << sel);
            seg <= seg_next;
            dp  <= !((sel == '0) && done_in);
        end
    end

endmodule

// File: tb/tb_cycle_count_display.sv
// Directed bench for cycle_count_display with a short scan counter.
module tb_cycle_count_display;

    localparam int ND = 8;
    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] count_in;
    logic        done_in;
    logic        busy;
    logic [ND-1:0] an;
    logic [6:0]  seg;
    logic        dp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cycle_count_display #(.NUM_DIGITS(ND), .REFRESH_BITS(RB)) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .done_in  (done_in),
        .busy     (busy),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [31:0] val, input int k);
        int unsigned p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (val > 32'd99999999) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && val < p) return 7'h7F;
`endif
        return seg_of(int'((val / p) % 10));
    endfunction

    // Capture seg while digit k is the active one (bounded wait)
    task automatic get_seg(input int k, output logic [6:0] s, output bit ok);
        logic [7:0] tgt;
        tgt = ~(8'd1 << k);
        ok  = 1'b0;
        s   = 7'h7F;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (an === tgt) begin
                ok = 1'b1;
                s  = seg;
            end
        end
    endtask

    // Wait for busy to drop, then one more cycle for the registered outputs
    task automatic wait_conv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 120 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [6:0] s;
        bit ok;
        rst = 1'b1; count_in = 32'd0; done_in = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || busy !== 1'b0 || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: an=%h seg=%h busy=%b dp=%b expected FF 7F 0 1", an, seg, busy, dp);
        end
        rst = 1'b0;
        count_in = 32'd42;
        repeat (6) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid_conv: busy=%b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (an !== 8'hFF || seg !== 7'h7F || busy !== 1'b0 || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: an=%h seg=%h busy=%b dp=%b expected FF 7F 0 1", an, seg, busy, dp);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_conv(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reconvert_timeout: busy=%b expected 0", busy);
        end
        for (int k = 0; k < 2; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg(32'd42, k)) begin
                miscompares++;
                $display("FAIL reconvert_digit%0d: seg=%h found=%0d expected %h", k, s, ok, exp_seg(32'd42, k));
            end
        end
    endtask

    task automatic test_convert;
        logic [6:0] s;
        bit ok;
        count_in = 32'd1234;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: busy=%b expected 1", busy);
        end
        repeat (32) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_last: busy=%b expected 1", busy);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall: busy=%b expected 0", busy);
        end
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg(32'd1234, k)) begin
                miscompares++;
                $display("FAIL convert_digit%0d: seg=%h found=%0d expected %h", k, s, ok, exp_seg(32'd1234, k));
            end
        end
    endtask

    task automatic test_mid_change;
        logic [6:0] s;
        bit ok;
        rst = 1'b1; count_in = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        get_seg(0, s, ok);
        vectors++;
        if (!ok || s !== 7'h40) begin
            miscompares++;
            $display("FAIL cleared_digit0: seg=%h found=%0d expected 40", s, ok);
        end
        count_in = 32'd1234;
        repeat (11) @(negedge clk);
        count_in = 32'd5678;
        wait_conv(ok);
        vectors++;
        if (!ok || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL retrigger: busy=%b found=%0d expected 1", busy, ok);
        end
        for (int k = 0; k < 4; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg(32'd1234, k)) begin
                miscompares++;
                $display("FAIL first_value_digit%0d: seg=%h found=%0d expected %h", k, s, ok, exp_seg(32'd1234, k));
            end
        end
        wait_conv(ok);
        for (int k = 0; k < ND; k++) begin
            get_seg(k, s, ok);
            vectors++;
            if (!ok || s !== exp_seg(32'd5678, k)) begin
                miscompares++;
                $display("FAIL final_value_digit%0d: seg=%h found=%0d expected %h", k, s, ok, exp_seg(32'd5678, k));
            end
        end
    endtask

    task automatic test_limits;
        logic [6:0] s;
        bit ok;
        logic [31:0] vals [3];
        vals[0] = 32'd100000000;
        vals[1] = 32'd99999999;
        vals[2] = 32'd0;
        for (int v = 0; v < 3; v++) begin
            count_in = vals[v];
            @(negedge clk);
            wait_conv(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL limit%0d_timeout: busy=%b expected 0", v, busy);
            end
            for (int k = 0; k < ND; k++) begin
                get_seg(k, s, ok);
                vectors++;
                if (!ok || s !== exp_seg(vals[v], k)) begin
                    miscompares++;
                    $display("FAIL limit%0d_digit%0d: seg=%h found=%0d expected %h", v, k, s, ok, exp_seg(vals[v], k));
                end
            end
        end
    endtask

    task automatic test_dp_scan;
        int prev;
        int cur;
        done_in = 1'b1;
        @(negedge clk);
        prev = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (dp !== ((an === 8'hFE) ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("FAIL dp_cycle%0d: dp=%b an=%h expected dp low only with an=FE", i, dp, an);
            end
            cur = -1;
            for (int k = 0; k < ND; k++) if (an === ~(8'd1 << k)) cur = k;
            vectors++;
            if (cur < 0 || (prev >= 0 && cur != prev && cur != (prev + 1) % ND)) begin
                miscompares++;
                $display("FAIL scan_cycle%0d: an=%h previous digit %0d expected one-hot-low successor", i, an, prev);
            end
            prev = cur;
        end
        done_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vectors++;
            if (dp !== 1'b1) begin
                miscompares++;
                $display("FAIL dp_off_cycle%0d: dp=%b expected 1", i, dp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_convert;
        test_mid_change;
        test_limits;
        test_dp_scan;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
